// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// Holds the FSM state encoding and the requester port indices.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/sram_arb_rr2.sv
// Two-way round-robin pick: on a tie the port that did not win last time is granted.
module sram_arb_rr2
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = PORT_CPU;
        if (req == 2'b11) begin
            gnt_idx = ~last_grant;
        end else if (req[PORT_DMA]) begin
            gnt_idx = PORT_DMA;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the single RW port of the 512x32 SRAM macro between the CPU (port 0) and
// the DMA/debug bus (port 1), one access in flight, Wishbone-classic single-cycle acks.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WMASKS = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,

    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic [NUM_WMASKS-1:0] r0_wmask,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_ack,
    output logic [DATA_WIDTH-1:0] r0_rdata,

    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic [NUM_WMASKS-1:0] r1_wmask,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_ack,
    output logic [DATA_WIDTH-1:0] r1_rdata,

    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,

    output logic                  arb_busy
);

    arb_state_e state_q, state_d;
    logic       gnt_q, gnt_d;
    logic       we_q, we_d;
    logic       last_grant_q, last_grant_d;

    logic                  csb_d, web_d;
    logic [NUM_WMASKS-1:0] wmask_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] din_d;

    logic [1:0] arb_req;
    logic       gnt_valid, gnt_idx;

    logic                  sel_we;
    logic [NUM_WMASKS-1:0] sel_wmask;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // In RESP only the other port may be granted; the current owner's req is stale.
    always_comb begin
        arb_req = 2'b00;
        if (state_q == IDLE) begin
            arb_req = {r1_req, r0_req};
        end else if (state_q == RESP) begin
            arb_req = (gnt_q == PORT_CPU) ? {r1_req, 1'b0} : {1'b0, r0_req};
        end
    end

    sram_arb_rr2 u_rr2 (
        .req        (arb_req),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    always_comb begin
        sel_we    = (gnt_idx == PORT_DMA) ? r1_we    : r0_we;
        sel_wmask = (gnt_idx == PORT_DMA) ? r1_wmask : r0_wmask;
        sel_addr  = (gnt_idx == PORT_DMA) ? r1_addr  : r0_addr;
        sel_wdata = (gnt_idx == PORT_DMA) ? r1_wdata : r0_wdata;
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        last_grant_d = last_grant_q;
        csb_d        = 1'b1;
        web_d        = 1'b1;
        wmask_d      = sram_wmask0;
        addr_d       = sram_addr0;
        din_d        = sram_din0;
        unique case (state_q)
            IDLE, RESP: begin
                if (gnt_valid) begin
                    state_d      = CMD;
                    gnt_d        = gnt_idx;
                    we_d         = sel_we;
                    last_grant_d = gnt_idx;
                    csb_d        = 1'b0;
                    web_d        = ~sel_we;
                    wmask_d      = sel_we ? sel_wmask : '0;
                    addr_d       = sel_addr;
                    din_d        = sel_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            CMD: begin
                state_d = RESP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            gnt_q        <= PORT_CPU;
            we_q         <= 1'b0;
            last_grant_q <= PORT_DMA;
            sram_csb0    <= 1'b1;
            sram_web0    <= 1'b1;
            sram_wmask0  <= '0;
            sram_addr0   <= '0;
            sram_din0    <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            last_grant_q <= last_grant_d;
            sram_csb0    <= csb_d;
            sram_web0    <= web_d;
            sram_wmask0  <= wmask_d;
            sram_addr0   <= addr_d;
            sram_din0    <= din_d;
        end
    end

    always_comb begin
        r0_ack   = (state_q == RESP) && (gnt_q == PORT_CPU);
        r1_ack   = (state_q == RESP) && (gnt_q == PORT_DMA);
        r0_rdata = (r0_ack && !we_q) ? sram_dout0 : '0;
        r1_rdata = (r1_ack && !we_q) ? sram_dout0 : '0;
        arb_busy = (state_q != IDLE);
    end

endmodule
